// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared op codes, widths, cycle defaults and FSM state type
//                for the EX-stage multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int unsigned MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_if.sv
// ============================================================================
//  Module      : ex_muldiv_if
//  Description : EX-stage operand/op bus into the MDU and its HI/LO/busy
//                results back to the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_muldiv_if;
    import mdu_pkg::*;

    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        md_a;
    logic [31:0]        md_b;
    logic               md_busy;
    logic [31:0]        md_hi;
    logic [31:0]        md_lo;

    modport master (
        output md_op, md_a, md_b,
        input  md_busy, md_hi, md_lo
    );

    modport slave (
        input  md_op, md_a, md_b,
        output md_busy, md_hi, md_lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_div_core.sv
// ============================================================================
//  Module      : mdu_div_core
//  Description : Combinational signed/unsigned 32-bit divide with
//                divide-by-zero and signed-overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_div_core (
    input  wire logic [31:0] dividend_i,
    input  wire logic [31:0] divisor_i,
    input  wire logic        signed_i,
    output logic      [31:0] quot_o,
    output logic      [31:0] rem_o,
    output logic             div_zero_o,
    output logic             overflow_o
);
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_abs;
    logic [31:0] w_r_abs;

    assign w_neg_a  = signed_i & dividend_i[31];
    assign w_neg_b  = signed_i & divisor_i[31];
    assign w_a_abs  = w_neg_a ? (32'd0 - dividend_i) : dividend_i;
    assign w_b_abs  = w_neg_b ? (32'd0 - divisor_i)  : divisor_i;

    // Divisor forced to 1 on zero so the divider never sees an undefined case.
    assign div_zero_o = (divisor_i == 32'd0);
    assign w_b_safe   = div_zero_o ? 32'd1 : w_b_abs;
    assign w_q_abs    = w_a_abs / w_b_safe;
    assign w_r_abs    = w_a_abs % w_b_safe;

    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign quot_o     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_abs) : w_q_abs;
    assign rem_o      = w_neg_a ? (32'd0 - w_r_abs) : w_r_abs;
    assign overflow_o = signed_i & (dividend_i == 32'h8000_0000)
                                 & (divisor_i  == 32'hFFFF_FFFF);
endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
//  Module      : ex_muldiv
//  Description : Multi-cycle mult/div unit owning HI/LO; raises md_busy while
//                a result is pending. Define MDU_MADD_EN to enable madd/maddu.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    ex_muldiv_if.slave  bus
);
    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

    md_state_e   state_q;
    logic [3:0]  cnt_q;
    logic [63:0] pend_q;
    logic        pend_wr_q;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        start_d;
    logic        wr_d;
    logic [3:0]  cyc_d;
    logic [63:0] result_d;
    logic [63:0] hilo_d;

    logic        w_mul_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;
    logic        w_div_ovf;

    // Sign- or zero-extend once so a single 64-bit multiplier serves both.
    assign w_mul_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_MADD);
    assign w_a_ext      = {{32{w_mul_signed & bus.md_a[31]}}, bus.md_a};
    assign w_b_ext      = {{32{w_mul_signed & bus.md_b[31]}}, bus.md_b};
    assign w_prod       = w_a_ext * w_b_ext;

    mdu_div_core u_div_core (
        .dividend_i (bus.md_a),
        .divisor_i  (bus.md_b),
        .signed_i   (bus.md_op == MD_DIV),
        .quot_o     (w_quot),
        .rem_o      (w_rem),
        .div_zero_o (w_div_zero),
        .overflow_o (w_div_ovf)
    );

`ifdef MDU_MADD_EN
    logic pend_acc_q;
    logic acc_d;
`endif

    always_comb begin
        start_d  = 1'b0;
        wr_d     = 1'b1;
        cyc_d    = C_MULT_CNT;
        result_d = w_prod;
`ifdef MDU_MADD_EN
        acc_d    = 1'b0;
`endif
        case (bus.md_op)
            MD_MULT, MD_MULTU: start_d = 1'b1;
            MD_DIV, MD_DIVU: begin
                start_d  = 1'b1;
                cyc_d    = C_DIV_CNT;
                wr_d     = ~w_div_zero;
                result_d = w_div_ovf ? {32'h0000_0000, 32'h8000_0000}
                                     : {w_rem, w_quot};
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: begin
                start_d = 1'b1;
                acc_d   = 1'b1;
            end
`endif
            default: start_d = 1'b0;
        endcase
    end

    // Accumulation uses HI/LO as they stand at commit, not at issue.
`ifdef MDU_MADD_EN
    assign hilo_d = pend_acc_q ? ({hi_q, lo_q} + pend_q) : pend_q;
`else
    assign hilo_d = pend_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            pend_q     <= 64'd0;
            pend_wr_q  <= 1'b0;
            busy_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
`ifdef MDU_MADD_EN
            pend_acc_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        pend_q     <= result_d;
                        pend_wr_q  <= wr_d;
                        cnt_q      <= cyc_d;
                        busy_q     <= 1'b1;
                        state_q    <= ST_BUSY;
`ifdef MDU_MADD_EN
                        pend_acc_q <= acc_d;
`endif
                    end else if (bus.md_op == MD_MTHI) begin
                        hi_q <= bus.md_a;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_q <= bus.md_a;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (pend_wr_q) begin
                            hi_q <= hilo_d[63:32];
                            lo_q <= hilo_d[31:0];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.md_busy = busy_q;
    assign bus.md_hi   = hi_q;
    assign bus.md_lo   = lo_q;
endmodule

`default_nettype wire
